fifo_router: RTL and testbench

FIFO_ROUTER -- requirements
Module: fifo_router

---
 rtl/fifo_router_pkg.sv | 14 +
 rtl/fifo_router.sv | 74 +++++++
 tb/tb_fifo_router.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fifo_router_pkg.sv
// Shared sizing constants and storage types for the router output FIFO.
package fifo_router_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int PTR_W  = 5;
  localparam int CNT_W  = 7;

  typedef logic [DATA_W:0]   entry_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/fifo_router.sv
// 16-deep router FIFO storing a header flag per byte and tracking the
// bytes left in the packet being drained so dout can float between packets.
module fifo_router
  import fifo_router_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  entry_t            mem [DEPTH];
  ptr_t              wr_ptr;
  ptr_t              rd_ptr;
  cnt_t              count;
  logic [DATA_W-1:0] dout_q;
  logic              dout_oe;
  logic              do_wr;
  logic              do_rd;
  entry_t            rd_entry;

  // Wrap bit distinguishes full from empty when the address bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);

  assign do_wr    = wr_en && !full;
  assign do_rd    = rd_en && !empty;
  assign rd_entry = mem[rd_ptr[ADDR_W-1:0]];

  assign dout = dout_oe ? dout_q : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      dout_q  <= '0;
      dout_oe <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (soft_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      dout_q  <= '0;
      dout_oe <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, d_in};
        wr_ptr                  <= wr_ptr + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        dout_q  <= rd_entry[DATA_W-1:0];
        dout_oe <= 1'b1;
        // Header byte carries payload length in [7:2]; +1 covers the parity byte.
        if (rd_entry[DATA_W])
          count <= CNT_W'(rd_entry[DATA_W-1:2]) + CNT_W'(1);
        else if (count != '0)
          count <= count - CNT_W'(1);
      end else if (count == '0) begin
        dout_oe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_router.sv
// Randomised and directed checks of fifo_router against a queue-based packet model.
module tb_fifo_router;

  logic       clk;
  logic       rst;
  logic       soft_rst;
  logic       wr_en;
  logic       rd_en;
  logic       lfd_state;
  logic [7:0] d_in;
  wire  [7:0] dout;
  wire        full;
  wire        empty;

  int compared   = 0;
  int mismatched = 0;

  logic [8:0] model_q [$];
  int         model_cnt;
  logic [7:0] model_dout;

  fifo_router dut (
    .clk       (clk),
    .rst       (rst),
    .soft_rst  (soft_rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .lfd_state (lfd_state),
    .d_in      (d_in),
    .dout      (dout),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag);
    logic exp_full;
    logic exp_empty;
    exp_full  = (model_q.size() == 16);
    exp_empty = (model_q.size() == 0);
    compared++;
    assert (dout === model_dout) else begin
      mismatched++;
      $error("[TB] FAIL %s dout: got %h expected %h", tag, dout, model_dout);
    end
    compared++;
    assert (full === exp_full) else begin
      mismatched++;
      $error("[TB] FAIL %s full: got %b expected %b", tag, full, exp_full);
    end
    compared++;
    assert (empty === exp_empty) else begin
      mismatched++;
      $error("[TB] FAIL %s empty: got %b expected %b", tag, empty, exp_empty);
    end
  endtask

  // One clock: drive inputs, advance the model from pre-edge state, compare at negedge.
  task automatic apply_stimulus(input logic r, input logic s, input logic w,
                                input logic rd, input logic l, input logic [7:0] d,
                                input string tag);
    logic [8:0] e;
    bit rd_ok;
    bit wr_ok;
    rst = r; soft_rst = s; wr_en = w; rd_en = rd; lfd_state = l; d_in = d;
    e = '0;
    if (!r) begin
      model_q.delete(); model_cnt = 0; model_dout = 8'h00;
    end else if (s) begin
      model_q.delete(); model_cnt = 0; model_dout = 8'hzz;
    end else begin
      rd_ok = rd && (model_q.size() != 0);
      wr_ok = w && (model_q.size() != 16);
      if (rd_ok) e = model_q.pop_front();
      if (wr_ok) model_q.push_back({l, d});
      if (rd_ok) begin
        model_dout = e[7:0];
        if (e[8]) model_cnt = int'(e[7:2]) + 1;
        else if (model_cnt > 0) model_cnt--;
      end else if (model_cnt == 0) begin
        model_dout = 8'hzz;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_output(tag);
  endtask

  initial begin
    logic [7:0] pkt [5];
    logic [7:0] v;
    pkt[0] = 8'h0C; pkt[1] = 8'hA1; pkt[2] = 8'hA2; pkt[3] = 8'hA3; pkt[4] = 8'h55;
    model_q.delete(); model_cnt = 0; model_dout = 8'h00;

    apply_stimulus(0, 0, 0, 0, 0, 8'h00, "hard_reset");
    apply_stimulus(1, 1, 0, 0, 0, 8'h00, "soft_reset");

    for (int i = 0; i < 5; i++)
      apply_stimulus(1, 0, 1, 0, (i == 0), pkt[i], "pkt_write");
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, 0, 0, 1, 0, 8'h00, "pkt_read");
      compared++;
      assert (dout === pkt[i]) else begin
        mismatched++;
        $error("[TB] FAIL pkt_byte%0d: got %h expected %h", i, dout, pkt[i]);
      end
    end
    apply_stimulus(1, 0, 0, 0, 0, 8'h00, "pkt_idle");
    compared++;
    assert (dout === 8'hzz) else begin
      mismatched++;
      $error("[TB] FAIL pkt_float: got %h expected zz", dout);
    end

    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom);
      apply_stimulus(1, 0, 1, 0, 0, v, "fill16");
    end
    apply_stimulus(1, 0, 1, 0, 0, 8'hEE, "write_when_full");
    for (int i = 0; i < 16; i++)
      apply_stimulus(1, 0, 0, 1, 0, 8'h00, "drain16");
    apply_stimulus(1, 0, 0, 1, 0, 8'h00, "read_when_empty");

    for (int i = 0; i < 10; i++) begin
      v = 8'($urandom);
      apply_stimulus(1, 0, 1, 0, (i == 0), v, "write10");
    end
    for (int i = 0; i < 12; i++)
      apply_stimulus(1, 0, 0, 1, 0, 8'h00, "read10");

    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom);
      apply_stimulus(1, 0, 1, 0, 0, v, "refill16");
    end
    apply_stimulus(1, 0, 1, 1, 0, 8'h77, "full_rd_wr");
    apply_stimulus(1, 0, 0, 0, 0, 8'h00, "after_full_rd_wr");

    apply_stimulus(1, 1, 0, 0, 0, 8'h00, "soft_flush");
    apply_stimulus(0, 0, 0, 0, 0, 8'h00, "hard_flush");

    for (int i = 0; i < 600; i++) begin
      v = 8'($urandom);
      apply_stimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 59) == 0),
                     ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0),
                     ($urandom_range(0, 5) == 0), v, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
